// File: rtl/i2s_receiver_pkg.sv
// Shared audio definitions for the I2S transmitter and receiver.
//   LRCLK_LEFT  : word-select level that marks the left channel
//   AUDIO_WIDTH : default bits per channel word
//   rx_state_e  : receiver FSM states
package i2s_receiver_pkg;

    localparam logic        LRCLK_LEFT  = 1'b0;
    localparam int unsigned AUDIO_WIDTH = 24;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StRun
    } rx_state_e;

endpackage

// File: rtl/i2s_receiver_if.sv
// I2S receive bus: serial inputs, enable and the deserialized stereo outputs.
//   slave  : the receiver (consumes sclk/lrclk/sd/enable, drives the sample outputs)
//   master : the stream source / sample consumer side
interface i2s_receiver_if
    import i2s_receiver_pkg::*;
#(
    parameter int unsigned WIDTH = AUDIO_WIDTH
);
    logic             enable;
    logic             sclk;
    logic             lrclk;
    logic             sd;
    logic [WIDTH-1:0] left_data;
    logic [WIDTH-1:0] right_data;
    logic             valid;
    logic             short_word;

    modport slave (
        input  enable, sclk, lrclk, sd,
        output left_data, right_data, valid, short_word
    );

    modport master (
        output enable, sclk, lrclk, sd,
        input  left_data, right_data, valid, short_word
    );
endinterface

// File: rtl/i2s_input_sync.sv
// Brings sclk, lrclk and sd into the clk domain through equal-depth 2-flop
// synchronizers and detects sclk rising edges.
//   clk, reset : system clock, async active-high reset
//   sclk/lrclk/sd : raw I2S inputs
//   sclk_rise  : one-clk pulse per synchronized sclk rising edge
//   lrclk_s/sd_s : synchronized word select and data, aligned with sclk_rise
module i2s_input_sync (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic lrclk,
    input  logic sd,
    output logic sclk_rise,
    output logic lrclk_s,
    output logic sd_s
);
    // Bit order in the synchronizer vectors: {sclk, lrclk, sd}
    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;
    logic       sclk_dly_q, sclk_dly_d;
    logic       rise_q, rise_d;
    logic       lrclk_q, lrclk_d;
    logic       sd_q, sd_d;

    // lrclk/sd get one extra stage so they stay aligned with the registered edge pulse.
    always_comb begin
        meta_d     = {sclk, lrclk, sd};
        sync_d     = meta_q;
        sclk_dly_d = sync_q[2];
        rise_d     = sync_q[2] & ~sclk_dly_q;
        lrclk_d    = sync_q[1];
        sd_d       = sync_q[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q     <= '0;
            sync_q     <= '0;
            sclk_dly_q <= 1'b0;
            rise_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sd_q       <= 1'b0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            sclk_dly_q <= sclk_dly_d;
            rise_q     <= rise_d;
            lrclk_q    <= lrclk_d;
            sd_q       <= sd_d;
        end
    end

    assign sclk_rise = rise_q;
    assign lrclk_s   = lrclk_q;
    assign sd_s      = sd_q;
endmodule

// File: rtl/i2s_receiver.sv
// Slave-mode I2S receiver. Deserializes MSB-first words with the standard
// one-bit word-select delay and presents one stereo pair per frame.
//   clk, reset : system clock, async active-high reset
//   bus        : i2s_receiver_if slave (enable, sclk, lrclk, sd in;
//                left_data, right_data, valid, short_word out)
module i2s_receiver
    import i2s_receiver_pkg::*;
#(
    parameter int unsigned WIDTH = AUDIO_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    i2s_receiver_if.slave bus
);
    localparam int unsigned     CntW   = $clog2(WIDTH + 1);
    localparam int unsigned     IdxW   = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

    logic sclk_rise;
    logic lrclk_s;
    logic sd_s;

    i2s_input_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .sclk      (bus.sclk),
        .lrclk     (bus.lrclk),
        .sd        (bus.sd),
        .sclk_rise (sclk_rise),
        .lrclk_s   (lrclk_s),
        .sd_s      (sd_s)
    );

    rx_state_e        state_q, state_d;
    logic             ws_prev_q, ws_prev_d;
    logic             ws_seen_q, ws_seen_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic [WIDTH-1:0] right_q, right_d;
    logic             have_left_q, have_left_d;
    logic             valid_q, valid_d;
    logic             short_q, short_d;

    logic             ws_change;
    logic [IdxW-1:0]  bit_idx;
    logic [WIDTH-1:0] word_bit;

    always_comb begin
        state_d     = state_q;
        ws_prev_d   = ws_prev_q;
        ws_seen_d   = ws_seen_q;
        bit_cnt_d   = bit_cnt_q;
        word_d      = word_q;
        left_d      = left_q;
        right_d     = right_q;
        have_left_d = have_left_q;
        valid_d     = 1'b0;
        short_d     = 1'b0;

        // ws_seen guards against a false change on the first edge after (re)start,
        // when ws_prev holds no real sample yet.
        ws_change = ws_seen_q && (lrclk_s != ws_prev_q);

        // Word with this edge's bit written in; extra bits past WIDTH are dropped.
        bit_idx  = IdxW'(WIDTH - 1) - IdxW'(bit_cnt_q);
        word_bit = word_q;
        if (bit_cnt_q < CntMax) begin
            word_bit[bit_idx] = sd_s;
        end

        if (!bus.enable) begin
            state_d     = StIdle;
            ws_seen_d   = 1'b0;
            bit_cnt_d   = '0;
            word_d      = '0;
            have_left_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSync;
                end
                StSync: begin
                    if (sclk_rise) begin
                        ws_prev_d = lrclk_s;
                        ws_seen_d = 1'b1;
                        if (ws_change) begin
                            state_d   = StRun;
                            bit_cnt_d = '0;
                            word_d    = '0;
                        end
                    end
                end
                StRun: begin
                    if (sclk_rise) begin
                        ws_prev_d = lrclk_s;
                        ws_seen_d = 1'b1;
                        if (ws_change) begin
                            // The change edge carries the LSB of the word being closed.
                            if (ws_prev_q == LRCLK_LEFT) begin
                                left_d      = word_bit;
                                have_left_d = 1'b1;
                            end else begin
                                right_d     = word_bit;
                                valid_d     = have_left_q;
                                have_left_d = 1'b0;
                            end
                            short_d   = bit_cnt_q < (CntMax - CntW'(1));
                            bit_cnt_d = '0;
                            word_d    = '0;
                        end else begin
                            word_d = word_bit;
                            if (bit_cnt_q < CntMax) begin
                                bit_cnt_d = bit_cnt_q + CntW'(1);
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ws_prev_q   <= 1'b0;
            ws_seen_q   <= 1'b0;
            bit_cnt_q   <= '0;
            word_q      <= '0;
            left_q      <= '0;
            right_q     <= '0;
            have_left_q <= 1'b0;
            valid_q     <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ws_prev_q   <= ws_prev_d;
            ws_seen_q   <= ws_seen_d;
            bit_cnt_q   <= bit_cnt_d;
            word_q      <= word_d;
            left_q      <= left_d;
            right_q     <= right_d;
            have_left_q <= have_left_d;
            valid_q     <= valid_d;
            short_q     <= short_d;
        end
    end

    assign bus.left_data  = left_q;
    assign bus.right_data = right_q;
    assign bus.valid      = valid_q;
    assign bus.short_word = short_q;
endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: drives I2S frames, predicts every commit from the
// words it sends, and checks the outputs on every clk cycle.
module tb_i2s_receiver;
    localparam int W    = 24;
    localparam int HALF = 4;  // clk periods per sclk phase
    localparam int LAT  = 4;  // clk edges from a mid-cycle sclk rise to the committed outputs

    typedef struct {
        int          due;
        bit          is_left;
        logic [23:0] word;
        bit          short_w;
        bit          vld;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_receiver_if #(.WIDTH(W)) bus ();

    i2s_receiver #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    ev_t         evq[$];
    logic [47:0] vlog[$];
    int          short_cnt = 0;
    logic [23:0] m_left = '0;
    logic [23:0] m_right = '0;
    bit          m_valid;
    bit          m_short;
    ev_t         cur;
    logic [31:0] w [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: outputs change only when a predicted commit falls due.
    always @(negedge clk) begin
        m_valid = 1'b0;
        m_short = 1'b0;
        if (reset) begin
            m_left  = '0;
            m_right = '0;
            evq.delete();
        end else if (evq.size() > 0 && evq[0].due == cyc) begin
            cur = evq.pop_front();
            if (cur.is_left) m_left = cur.word;
            else m_right = cur.word;
            m_valid = cur.vld;
            m_short = cur.short_w;
        end
        check("valid", {31'b0, bus.valid}, {31'b0, m_valid});
        check("short_word", {31'b0, bus.short_word}, {31'b0, m_short});
        check("left_data", {8'b0, bus.left_data}, {8'b0, m_left});
        check("right_data", {8'b0, bus.right_data}, {8'b0, m_right});
        if (bus.valid === 1'b1) vlog.push_back({bus.left_data, bus.right_data});
        if (bus.short_word === 1'b1) short_cnt++;
    end

    function automatic logic [23:0] fmt(input logic [31:0] v, input int n);
        logic [31:0] t;
        if (n >= W) t = v >> (n - W);
        else t = v << (W - n);
        return t[23:0];
    endfunction

    // One sclk period; called at a negedge of clk.
    task automatic drive_bit(input bit ws, input bit b, input bit push, input bit is_left,
                             input logic [23:0] word, input bit short_w, input bit vld);
        ev_t ev;
        bus.sclk  = 1'b0;
        bus.lrclk = ws;
        bus.sd    = b;
        repeat (HALF) @(negedge clk);
        bus.sclk = 1'b1;
        if (push) begin
            ev.due     = cyc + LAT;
            ev.is_left = is_left;
            ev.word    = word;
            ev.short_w = short_w;
            ev.vld     = vld;
            evq.push_back(ev);
        end
        repeat (HALF) @(negedge clk);
    endtask

    // Word 0 only synchronizes; each later word commits on its LSB edge, where
    // lrclk already shows the next channel. valid on right words after a left commit.
    task automatic send_segment(input int n, input bit ch0, input int start_bit, input int nw,
                                input logic [31:0] wv [8]);
        bit ch;
        bit last;
        for (int k = 0; k < nw; k++) begin
            ch = ch0 ^ k[0];
            for (int i = (k == 0) ? start_bit : 0; i < n; i++) begin
                last = (i == n - 1);
                drive_bit(last ? ~ch : ch, wv[k][n-1-i], last && (k >= 1), ch == 1'b0,
                          fmt(wv[k], n), n < W, (ch == 1'b1) && (k >= 2));
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic restart();
        bus.enable = 1'b0;
        repeat (4) @(negedge clk);
        bus.enable = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_logs();
        vlog.delete();
        short_cnt = 0;
    endtask

    task automatic check_pair(input string name, input int idx, input logic [23:0] l,
                              input logic [23:0] r);
        logic [47:0] p;
        p = (idx < vlog.size()) ? vlog[idx] : 'x;
        check({name, "_left"}, {8'b0, p[47:24]}, {8'b0, l});
        check({name, "_right"}, {8'b0, p[23:0]}, {8'b0, r});
    endtask

    initial begin
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.sclk   = 1'b0;
        bus.lrclk  = 1'b0;
        bus.sd     = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_left", {8'b0, bus.left_data}, 32'h0);
        check("rst_right", {8'b0, bus.right_data}, 32'h0);
        check("rst_valid", {31'b0, bus.valid}, 32'h0);
        check("rst_short", {31'b0, bus.short_word}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full 24-bit frames, then new values mid-stream.
        clear_logs();
        restart();
        w = '{32'hffffff, 32'h000000, 32'hffffff, 32'h000000,
              32'h010101, 32'h101010, 32'h010101, 32'h101010};
        send_segment(24, 1'b0, 0, 8, w);
        check("a_valid_cnt", vlog.size(), 3);
        check_pair("a_frame0", 0, 24'hffffff, 24'h000000);
        check_pair("a_frame1", 1, 24'h010101, 24'h101010);
        check("a_short_cnt", short_cnt, 0);

        // 16-bit words: zero padded, short on every commit.
        clear_logs();
        restart();
        w = '{32'ha5a5, 32'h3c3c, 32'ha5a5, 32'h3c3c, 32'h0, 32'h0, 32'h0, 32'h0};
        send_segment(16, 1'b0, 0, 4, w);
        check("b_valid_cnt", vlog.size(), 1);
        check_pair("b_frame0", 0, 24'ha5a500, 24'h3c3c00);
        check("b_short_cnt", short_cnt, 3);

        // 32-bit words: truncated to the top 24 bits.
        clear_logs();
        restart();
        w = '{32'h12345678, 32'h00000000, 32'h12345678, 32'h9abcdef0,
              32'h0, 32'h0, 32'h0, 32'h0};
        send_segment(32, 1'b0, 0, 4, w);
        check("c_valid_cnt", vlog.size(), 1);
        check_pair("c_frame0", 0, 24'h123456, 24'h9abcde);
        check("c_short_cnt", short_cnt, 0);

        // Partial left word, enable low for 10 sclk periods with lrclk toggling.
        clear_logs();
        for (int i = 0; i < 6; i++) drive_bit(1'b0, i[0], 1'b0, 1'b0, '0, 1'b0, 1'b0);
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) drive_bit((i / 3) % 2 == 1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("hold_left", {8'b0, bus.left_data}, 32'h123456);
        check("hold_right", {8'b0, bus.right_data}, 32'h9abcde);

        // Re-enable: the first lrclk change only synchronizes, then capture a partial word.
        bus.enable = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) drive_bit(i >= 5, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("sync_left", {8'b0, bus.left_data}, 32'h123456);
        check("sync_right", {8'b0, bus.right_data}, 32'h9abcde);
        check("sync_valid_cnt", vlog.size(), 0);

        // Asynchronous reset mid-word clears outputs without waiting for clk.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_left", {8'b0, bus.left_data}, 32'h0);
        check("arst_right", {8'b0, bus.right_data}, 32'h0);
        check("arst_valid", {31'b0, bus.valid}, 32'h0);
        check("arst_short", {31'b0, bus.short_word}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Stream picked up mid-right-word: first commit is left with no valid.
        clear_logs();
        w = '{32'h777777, 32'h111111, 32'h222222, 32'h333333, 32'h444444,
              32'h0, 32'h0, 32'h0};
        send_segment(24, 1'b1, 10, 5, w);
        check("d_valid_cnt", vlog.size(), 2);
        check_pair("d_frame0", 0, 24'h111111, 24'h222222);
        check_pair("d_frame1", 1, 24'h333333, 24'h444444);

        repeat (10) @(negedge clk);
        check("queue_drained", evq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

Slave-mode I2S receiver. It accepts externally generated sclk, lrclk and sd (codec ADC output, or our own I2S transmitter in loopback), synchronizes them into the system clock domain, and deserializes the stream MSB-first. It presents one stereo sample pair per frame with a single-cycle valid strobe. It is the receive-side counterpart of the I2S transmitter and feeds the audio processing pipeline.

## Interface
- WIDTH, 24, bits per channel word delivered on left_data/right_data
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  high = receive; low = discard in-progress word, hold outputs
- sclk  in  1  I2S bit clock (asynchronous to clk)
- lrclk  in  1  I2S word select: low = left, high = right
- sd  in  1  I2S serial data, changes on sclk falling edge
- left_data  out  WIDTH  last committed left word, held until next commit
- right_data  out  WIDTH  last committed right word, held until next commit
- valid  out  1  one-clk pulse: left_data/right_data form a new frame
- short_word  out  1  one-clk pulse: committed word had fewer than WIDTH bits

## Operation
- sclk, lrclk, sd each pass through a 2-flop synchronizer. All three use the same depth so their relative alignment is kept.
- sclk_rise = sclk_s & ~sclk_d. Data and word select are acted on only in cycles where sclk_rise is high.
- Standard I2S one-bit delay. The rising edge where sampled lrclk differs from the previous sampled lrclk (ws_prev) carries the LSB of the previous channel's word. The MSB of the new channel arrives on the following edge.
- Bit capture: the word register is cleared at word start. Each bit is written at index WIDTH-1-bit_cnt while bit_cnt < WIDTH. bit_cnt saturates at WIDTH.
  - Extra bits beyond WIDTH are ignored (truncated).
  - Short words are zero-padded at the LSB end.
- Commit happens on the lrclk-change edge, after writing that edge's bit:
  - the word goes to left_data if ws_prev = 0, otherwise to right_data;
  - bit_cnt is cleared;
  - short_word pulses if the final count < WIDTH.
- FSM states:
  - IDLE: after reset, or while enable = 0. Waits for enable = 1 and moves to SYNC.
  - SYNC: ignores data until the first lrclk change, then moves to RUN. That first change commits nothing.
  - RUN: normal capture.
  - enable = 0 in any state returns to IDLE, discards the partial word and clears have_left.
- have_left flag: set on a left commit, cleared on a right commit. valid pulses on a right commit only if have_left = 1, so a partial first frame never produces valid.
- Outputs hold their values across enable = 0.
- reset asserted mid-frame: all state and outputs return to reset values immediately; the next frame is re-acquired through SYNC.

## Timing
- Reset values: left_data = 0, right_data = 0, valid = 0, short_word = 0, state = IDLE, bit_cnt = 0, have_left = 0.
- Latency: external sclk rising edge → sclk_rise high after 3 clk edges (2 sync + 1 edge detect). Commit registers, valid and short_word update on the next clk edge, giving a total of 3–4 clk from the external edge.
- valid and short_word are high for exactly one clk cycle per commit. left_data and right_data are stable in the cycle valid is high.
- Constraint: sclk high and low phases each ≥ 3 clk periods. Behaviour is unspecified for faster sclk.
- Missing edges during a long enable-low period: no effect (IDLE).

## Structure
- Shared audio package holds the I2S channel encoding constant (LRCLK_LEFT = 0) and the default audio word width (24), used by both transmitter and receiver.
- Sub-module i2s_input_sync: 3-bit 2-flop synchronizer plus the sclk rising-edge detector. Outputs are sclk_rise, lrclk_s and sd_s.
- Top contains the FSM, bit counter, capture register and output registers.

## Test plan
- Loopback from I2S transmitter (WIDTH = 24), left = ffffff, right = 000000 → after the first full frame, valid pulses with left_data = ffffff and right_data = 000000. No short_word.
- Change transmitter inputs mid-stream to left = 010101, right = 101010 → within two frames, valid pulses with exactly those values. No intermediate mixed pair.
- Bench-driven 16-bit words, left = a5a5, right = 3c3c, at WIDTH = 24 → left_data = a5a500, right_data = 3c3c00, with short_word pulsing on each commit.
- Bench-driven 32-bit words, left = 12345678 → left_data = 123456. No short_word.
- Start stream mid-right-word after reset → the first commit is a left word with no valid. The first valid comes after the following right commit.
- Drop enable for 10 sclk periods mid-word → outputs hold. After re-enable, nothing is committed until SYNC passes. Async reset mid-word → all outputs are 0 in the same cycle.
